// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC3 memory responder.
// Port FSM states and the default wait-state counts live here.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } portState_t;

    localparam int DEFAULT_INSTR_WAIT = 1;
    localparam int DEFAULT_DATA_WAIT  = 2;

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// One request/complete handshake FSM with a programmable wait counter.
// accept marks the IDLE-exit edge, fire marks the edge entering RESP.
module lc3_mem_port_fsm
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    output logic accept,
    output logic fire,
    output logic complete
);

    localparam logic [3:0] RELOAD =
        4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam logic NO_WAIT = (WAIT_CYCLES == 0);

    portState_t state;
    logic [3:0] count;

    always_comb begin
        accept = (state == IDLE) && req;
        fire   = 1'b0;
        unique case (state)
            IDLE:    fire = req && NO_WAIT;
            WAIT:    fire = req && (count == 4'd0);
            default: fire = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            complete <= 1'b0;
        end else begin
            complete <= fire;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state <= NO_WAIT ? RESP : WAIT;
                        count <= RELOAD;
                    end
                end
                WAIT: begin
                    // Dropping the request mid-wait abandons the access.
                    if (!req) begin
                        state <= IDLE;
                        count <= 4'd0;
                    end else if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Dual-port (instruction + data) LC3 memory model with wait states.
// Backdoor load port preloads programs and wins over data writes.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int INSTR_WAIT = DEFAULT_INSTR_WAIT,
    parameter int DATA_WAIT  = DEFAULT_DATA_WAIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic [15:0] Data_addr,
    input  logic        data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_dout,
    output logic [15:0] Data_din,
    output logic        complete_data,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data
);

    localparam int DEPTH = 1 << ADDR_BITS;
    typedef logic [ADDR_BITS-1:0] index_t;

    logic [15:0] mem [DEPTH];

    logic   instrAccept, instrFire;
    logic   dataAccept, dataFire;
    index_t instrIdxQ, dataIdxQ;
    logic   dataRdQ;
    index_t instrIdx, dataIdx, loadIdx;
    logic   dataRd, dataWrite;
    logic   unusedAddrBits;

    lc3_mem_port_fsm #(.WAIT_CYCLES(INSTR_WAIT)) instrPort (
        .clock    (clock),
        .reset    (reset),
        .req      (instrmem_rd),
        .accept   (instrAccept),
        .fire     (instrFire),
        .complete (complete_instr)
    );

    lc3_mem_port_fsm #(.WAIT_CYCLES(DATA_WAIT)) dataPort (
        .clock    (clock),
        .reset    (reset),
        .req      (data_req),
        .accept   (dataAccept),
        .fire     (dataFire),
        .complete (complete_data)
    );

    // Zero-wait accesses use the live address on the accept edge.
    assign instrIdx  = instrAccept ? pc[ADDR_BITS-1:0] : instrIdxQ;
    assign dataIdx   = dataAccept ? Data_addr[ADDR_BITS-1:0] : dataIdxQ;
    assign dataRd    = dataAccept ? Data_rd : dataRdQ;
    assign loadIdx   = load_addr[ADDR_BITS-1:0];
    assign dataWrite = dataFire && !dataRd && reset;

    assign unusedAddrBits = ^{pc[15:ADDR_BITS],
                              Data_addr[15:ADDR_BITS],
                              load_addr[15:ADDR_BITS]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instrIdxQ <= '0;
            dataIdxQ  <= '0;
            dataRdQ   <= 1'b0;
        end else begin
            if (instrAccept) instrIdxQ <= pc[ADDR_BITS-1:0];
            if (dataAccept) begin
                dataIdxQ <= Data_addr[ADDR_BITS-1:0];
                dataRdQ  <= Data_rd;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Instr_dout <= 16'h0000;
            Data_din   <= 16'h0000;
        end else begin
            if (instrFire) Instr_dout <= mem[instrIdx];
            if (dataFire && dataRd) Data_din <= mem[dataIdx];
        end
    end

    // Load is written last so it overrides a same-edge data write.
    always_ff @(posedge clock) begin
        if (dataWrite) mem[dataIdx] <= Data_dout;
        if (load_en) mem[loadIdx] <= load_data;
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed self-checking bench for lc3_mem_responder (default parameters).
module tb_lc3_mem_responder;

    logic        clock;
    logic        reset;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic [15:0] Data_addr;
    logic        data_req;
    logic        Data_rd;
    logic [15:0] Data_dout;
    logic [15:0] Data_din;
    logic        complete_data;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;

    int checks = 0;
    int errors = 0;

    lc3_mem_responder dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .Data_addr      (Data_addr),
        .data_req       (data_req),
        .Data_rd        (Data_rd),
        .Data_dout      (Data_dout),
        .Data_din       (Data_din),
        .complete_data  (complete_data),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // INSTR_WAIT = 1: complete one cycle after the request edge.
    task automatic fetch(input logic [15:0] a, input logic [15:0] exp,
                         input string tag);
        instrmem_rd = 1'b1;
        pc = a;
        tick();
        chk({tag, "/wait"}, {15'd0, complete_instr}, 16'd0);
        pc = a ^ 16'h0042;
        tick();
        chk({tag, "/ci"}, {15'd0, complete_instr}, 16'd1);
        chk({tag, "/dout"}, Instr_dout, exp);
        instrmem_rd = 1'b0;
        tick();
        chk({tag, "/end"}, {15'd0, complete_instr}, 16'd0);
        chk({tag, "/hold"}, Instr_dout, exp);
    endtask

    // DATA_WAIT = 2; address and direction are scrambled during WAIT.
    task automatic dataAcc(input logic [15:0] a, input logic rd,
                           input logic [15:0] wd, input logic [15:0] exp,
                           input string tag);
        data_req  = 1'b1;
        Data_rd   = rd;
        Data_addr = a;
        Data_dout = wd;
        tick();
        chk({tag, "/w1"}, {15'd0, complete_data}, 16'd0);
        Data_addr = a ^ 16'h0045;
        Data_rd   = !rd;
        tick();
        chk({tag, "/w2"}, {15'd0, complete_data}, 16'd0);
        tick();
        chk({tag, "/cd"}, {15'd0, complete_data}, 16'd1);
        chk({tag, "/din"}, Data_din, exp);
        data_req = 1'b0;
        tick();
        chk({tag, "/end"}, {15'd0, complete_data}, 16'd0);
    endtask

    initial begin
        reset       = 1'b0;
        pc          = 16'h0000;
        instrmem_rd = 1'b0;
        Data_addr   = 16'h0000;
        data_req    = 1'b0;
        Data_rd     = 1'b0;
        Data_dout   = 16'h0000;
        load_en     = 1'b0;
        load_addr   = 16'h0000;
        load_data   = 16'h0000;
        tick();

        load(16'h3000, 16'h1220);
        load(16'h0020, 16'h1111);
        load(16'h0010, 16'h0000);
        chk("rst/ci", {15'd0, complete_instr}, 16'd0);
        chk("rst/cd", {15'd0, complete_data}, 16'd0);
        chk("rst/idout", Instr_dout, 16'h0000);
        chk("rst/ddin", Data_din, 16'h0000);
        reset = 1'b1;
        tick();

        fetch(16'h3000, 16'h1220, "fetch041");

        dataAcc(16'h0010, 1'b0, 16'hBEEF, 16'h0000, "wr042");
        dataAcc(16'h0010, 1'b1, 16'h0000, 16'hBEEF, "rd042");

        data_req  = 1'b1;
        Data_rd   = 1'b0;
        Data_addr = 16'h0010;
        Data_dout = 16'h1234;
        tick();
        chk("abort/w1", {15'd0, complete_data}, 16'd0);
        data_req = 1'b0;
        tick();
        chk("abort/a1", {15'd0, complete_data}, 16'd0);
        tick();
        chk("abort/a2", {15'd0, complete_data}, 16'd0);
        dataAcc(16'h0020, 1'b1, 16'h0000, 16'h1111, "abort/rdA");
        dataAcc(16'h0010, 1'b1, 16'h0000, 16'hBEEF, "abort/rdB");

        data_req  = 1'b1;
        Data_rd   = 1'b0;
        Data_addr = 16'h0020;
        Data_dout = 16'h5555;
        tick();
        chk("rbw/cd0", {15'd0, complete_data}, 16'd0);
        instrmem_rd = 1'b1;
        pc = 16'h0020;
        tick();
        chk("rbw/cd1", {15'd0, complete_data}, 16'd0);
        chk("rbw/ci1", {15'd0, complete_instr}, 16'd0);
        tick();
        chk("rbw/cd", {15'd0, complete_data}, 16'd1);
        chk("rbw/ci", {15'd0, complete_instr}, 16'd1);
        chk("rbw/old", Instr_dout, 16'h1111);
        chk("rbw/din", Data_din, 16'hBEEF);
        data_req = 1'b0;
        instrmem_rd = 1'b0;
        tick();
        chk("rbw/cdEnd", {15'd0, complete_data}, 16'd0);
        fetch(16'h0020, 16'h5555, "rbw/new");

        data_req  = 1'b1;
        Data_rd   = 1'b0;
        Data_addr = 16'h0030;
        Data_dout = 16'hAAAA;
        tick();
        tick();
        load_en   = 1'b1;
        load_addr = 16'h0030;
        load_data = 16'h7777;
        tick();
        chk("ldwin/cd", {15'd0, complete_data}, 16'd1);
        load_en  = 1'b0;
        data_req = 1'b0;
        tick();
        dataAcc(16'h0030, 1'b1, 16'h0000, 16'h7777, "ldwin/rd");

        fetch(16'h3100, 16'h1220, "wrap046");
        dataAcc(16'h0110, 1'b1, 16'h0000, 16'hBEEF, "wrapData");

        instrmem_rd = 1'b1;
        pc = 16'h3000;
        tick();
        chk("b2b/w1", {15'd0, complete_instr}, 16'd0);
        tick();
        chk("b2b/c1", {15'd0, complete_instr}, 16'd1);
        chk("b2b/d1", Instr_dout, 16'h1220);
        pc = 16'h0020;
        tick();
        chk("b2b/idle", {15'd0, complete_instr}, 16'd0);
        tick();
        chk("b2b/w2", {15'd0, complete_instr}, 16'd0);
        tick();
        chk("b2b/c2", {15'd0, complete_instr}, 16'd1);
        chk("b2b/d2", Instr_dout, 16'h5555);
        instrmem_rd = 1'b0;
        tick();
        chk("b2b/end", {15'd0, complete_instr}, 16'd0);

        instrmem_rd = 1'b1;
        pc = 16'h3000;
        data_req  = 1'b1;
        Data_rd   = 1'b0;
        Data_addr = 16'h3000;
        Data_dout = 16'hDEAD;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rst2/ci", {15'd0, complete_instr}, 16'd0);
        chk("rst2/cd", {15'd0, complete_data}, 16'd0);
        chk("rst2/idout", Instr_dout, 16'h0000);
        chk("rst2/ddin", Data_din, 16'h0000);
        tick();
        tick();
        chk("rst2/holdCd", {15'd0, complete_data}, 16'd0);
        chk("rst2/holdCi", {15'd0, complete_instr}, 16'd0);
        instrmem_rd = 1'b0;
        data_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        fetch(16'h3000, 16'h1220, "rst2/keep");
        dataAcc(16'h3000, 1'b1, 16'h0000, 16'h1220, "rst2/noWr");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
